adc_scan_ctrl: RTL and testbench
================================

# adc_scan_ctrl

Round-robin conversion scheduler that shares one `flash_adc` instance among `N_CH` requesting channels. Per conversion it steers the analog input mux and waits a programmable settle time, then strobes and averages `2^AVG_LOG` ADC samples. It returns the averaged code with the channel id and acknowledges the requester. It sits between the digital channel requesters and the flash ADC/input-mux datapath.

## Interface
- `N` — 3 — ADC resolution in bits; width of `adc_q` and `res_data`.
- `N_CH` — 4 — number of requesting channels (≥2).
- `SETTLE` — 2 — mux settle cycles before the first sample (0 allowed).
- `AVG_LOG` — 1 — log2 of the number of samples averaged per conversion (0 allowed).
- `clk` input 1 — single clock; all state changes on rising edge.
- `rst_n` input 1 — reset; asynchronous, active-low.
- `req` input `N_CH` — per-channel conversion request, level; held until that channel's `ack`.
- `adc_q` input `N` — flash ADC output code, valid during `sample`.
- `mux_sel` output `$clog2(N_CH)` — analog mux select driving the ADC `VIN`.
- `sample` output 1 — high for each cycle in which `adc_q` is captured.
- `busy` output 1 — high in every state except IDLE.
- `ack` output `N_CH` — one-hot, one-cycle pulse to the served channel.
- `res_valid` output 1 — one-cycle pulse; `res_data`/`res_ch` are new.
- `res_ch` output `$clog2(N_CH)` — channel the result belongs to.
- `res_data` output `N` — averaged conversion code.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Round-robin pointer `ptr`, reset 0.
- **IDLE:**
  - If `req != 0`, grant the lowest index ≥ `ptr` with `req` set, wrapping modulo `N_CH`.
  - Latch the granted index into `ch`. `mux_sel <= ch`. Clear the accumulator and the settle/sample counters.
  - Next state is SETTLE, or SAMPLE if `SETTLE == 0`.
  - If `req == 0`, stay in IDLE. `mux_sel` holds its last value.
- **SETTLE:** count `SETTLE` cycles, then go to SAMPLE.
- **SAMPLE:**
  - `sample = 1`; `acc += adc_q` every cycle.
  - Lasts exactly `2^AVG_LOG` consecutive cycles; `mux_sel` is stable throughout. Then go to DONE.
- **Accumulator:** `N+AVG_LOG` bits; cannot overflow.
- **DONE:**
  - `res_data <= acc >> AVG_LOG`, computed from the final accumulated value including the last sample. Fraction truncated, no rounding.
  - `res_ch <= ch`; `res_valid = 1`; `ack[ch] = 1`.
  - `ptr <= (ch+1) mod N_CH`. Next state is IDLE.
- `res_data` and `res_ch` hold until the next DONE.
- **Requests changing mid-conversion:**
  - A request deasserted mid-conversion does not abort it: the result and `ack` are still produced.
  - A request asserted mid-conversion waits for IDLE.
- A requester that keeps `req` high after `ack` is re-arbitrated normally. With the pointer advanced, all other pending channels are served first.
- `busy`, `sample`, `ack` and `res_valid` are functions of state; no extra registered delay.

## Timing
- **Reset (async assert):**
  - State IDLE, `ptr = 0`.
  - `mux_sel`, `sample`, `busy`, `ack`, `res_valid`, `res_ch`, `res_data` all 0; accumulator 0.
  - Reset mid-conversion discards the conversion: no `ack`, no `res_valid`.
- **Cycle numbering:** grant in IDLE at cycle T.
  - `mux_sel` is new from T+1.
  - SETTLE spans T+1..T+SETTLE.
  - `sample` is high T+SETTLE+1..T+SETTLE+2^AVG_LOG.
  - DONE (`ack`, `res_valid`) is at T+SETTLE+2^AVG_LOG+1.
  - The next grant is possible at T+SETTLE+2^AVG_LOG+2.
- **Latency:** defaults give grant→`res_valid` = 5 cycles; back-to-back throughput = one conversion per 6 cycles.
- **Degenerate parameters:** `SETTLE=0` and `AVG_LOG=0` give `sample` at T+1 and DONE at T+2.
- `ack` and `res_valid` are always coincident and never high in consecutive cycles.

## Test plan
- **Reset:** reset low with `req=4'b1111` → all outputs 0, `busy=0`, no `sample`. Release reset → grant ch0 on the first edge; `mux_sel=0` next cycle.
- **Single request, averaging:**
  - Stimulus: defaults; `req=4'b0100` at T; `adc_q=5` at T+3 and `adc_q=6` at T+4.
  - Required: `sample` high T+3..T+4; at T+5 `res_valid=1`, `ack=4'b0100`, `res_ch=2`, `res_data=5` (11>>1).
- **Round robin:** `req=4'b1011` held continuously (each channel re-asserts) → service order 0,1,3,0,1,3; `res_ch` sequence matches; 6-cycle spacing between `res_valid` pulses.
- **Fairness after wrap:** `ptr=3` (last grant was ch2), `req=4'b0101` → ch0 served, then ch2; ch2 not served twice in a row while ch0 pending.
- **Mid-flight events:**
  - Drop `req[1]` during SETTLE → conversion completes, `ack[1]` pulses.
  - Assert rst_n=0 during SAMPLE → immediate zero outputs, no `res_valid`; after release the state is IDLE with `ptr=0`.
- **Degenerate parameters:** `SETTLE=0`, `AVG_LOG=0`, `N=3`, `adc_q=7` → `sample` at T+1; `res_data=7`, `res_valid` at T+2.

Source files
------------

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: round-robin scheduler sharing one flash ADC among N_CH
// requesters. A conversion steers the input mux, waits SETTLE cycles,
// averages 2^AVG_LOG samples, then returns the code with its channel id
// and acks the requester.
//
// Handshake: req[i] is a level request that the requester holds until it
// sees the one-cycle ack[i]. A request that drops after its grant still
// completes and is still acked. A request that rises mid-conversion waits
// for the next IDLE arbitration. res_valid pulses together with ack, and
// res_data/res_ch hold until the next result.
module adc_scan_ctrl #(
  parameter int N       = 3,
  parameter int N_CH    = 4,
  parameter int SETTLE  = 2,
  parameter int AVG_LOG = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         req,
  input  logic [N-1:0]            adc_q,
  output logic [$clog2(N_CH)-1:0] mux_sel,
  output logic                    sample,
  output logic                    busy,
  output logic [N_CH-1:0]         ack,
  output logic                    res_valid,
  output logic [$clog2(N_CH)-1:0] res_ch,
  output logic [N-1:0]            res_data,
  output logic [1:0]              dbg_state
);

  localparam int CW  = $clog2(N_CH);
  localparam int AW  = N + AVG_LOG;
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int MCW = (AVG_LOG > 0) ? AVG_LOG : 1;
  localparam int NS  = 1 << AVG_LOG;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [CW-1:0]   mux_sel_q, mux_sel_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [SCW-1:0]  scnt_q, scnt_d;
  logic [MCW-1:0]  mcnt_q, mcnt_d;
  logic [N-1:0]    res_data_q, res_data_d;
  logic [CW-1:0]   res_ch_q, res_ch_d;
  logic            sample_q, sample_d;
  logic            busy_q, busy_d;
  logic            res_valid_q, res_valid_d;
  logic [N_CH-1:0] ack_q, ack_d;

  logic            gnt_found;
  logic [CW-1:0]   gnt_idx;
  logic [AW-1:0]   acc_sum;

  // Round-robin pick: first requester at or after ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!gnt_found && req[CW'((int'(ptr_q) + i) % N_CH)]) begin
        gnt_found = 1'b1;
        gnt_idx   = CW'((int'(ptr_q) + i) % N_CH);
      end
    end
  end

  // Next-state and datapath decode; outputs are derived from the next
  // state so the registered copies line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ch_d       = ch_q;
    mux_sel_d  = mux_sel_q;
    acc_d      = acc_q;
    scnt_d     = scnt_q;
    mcnt_d     = mcnt_q;
    res_data_d = res_data_q;
    res_ch_d   = res_ch_q;
    acc_sum    = acc_q + AW'(adc_q);

    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          ch_d      = gnt_idx;
          mux_sel_d = gnt_idx;
          acc_d     = '0;
          scnt_d    = '0;
          mcnt_d    = '0;
          state_d   = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (scnt_q == SCW'(SETTLE - 1)) state_d = S_SAMPLE;
        else                            scnt_d  = scnt_q + 1'b1;
      end
      S_SAMPLE: begin
        acc_d = acc_sum;
        if (mcnt_q == MCW'(NS - 1)) begin
          // Result includes the sample captured in this last cycle.
          state_d    = S_DONE;
          res_data_d = N'(acc_sum >> AVG_LOG);
          res_ch_d   = ch_q;
          ptr_d      = CW'((int'(ch_q) + 1) % N_CH);
        end else begin
          mcnt_d = mcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    sample_d    = (state_d == S_SAMPLE);
    busy_d      = (state_d != S_IDLE);
    res_valid_d = (state_d == S_DONE);
    ack_d       = res_valid_d ? (N_CH'(1) << ch_d) : '0;
  end

  // Single state register for the FSM, its datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      ch_q        <= '0;
      mux_sel_q   <= '0;
      acc_q       <= '0;
      scnt_q      <= '0;
      mcnt_q      <= '0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      sample_q    <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      ack_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ch_q        <= ch_d;
      mux_sel_q   <= mux_sel_d;
      acc_q       <= acc_d;
      scnt_q      <= scnt_d;
      mcnt_q      <= mcnt_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      sample_q    <= sample_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      ack_q       <= ack_d;
    end
  end

  assign mux_sel   = mux_sel_q;
  assign sample    = sample_q;
  assign busy      = busy_q;
  assign ack       = ack_q;
  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_data  = res_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl: default-parameter instance plus a
// SETTLE=0 / AVG_LOG=0 instance sharing clock and reset.
module tb_adc_scan_ctrl;

  logic       clk;
  logic       rst_n;

  // default instance
  logic [3:0] req;
  logic [2:0] adc_q;
  logic [1:0] mux_sel;
  logic       sample;
  logic       busy;
  logic [3:0] ack;
  logic       res_valid;
  logic [1:0] res_ch;
  logic [2:0] res_data;
  logic [1:0] dbg_state;

  // degenerate instance
  logic [3:0] req2;
  logic [2:0] adc2;
  logic [1:0] mux_sel2;
  logic       sample2;
  logic       busy2;
  logic [3:0] ack2;
  logic       res_valid2;
  logic [1:0] res_ch2;
  logic [2:0] res_data2;
  logic [1:0] dbg_state2;

  int n_vec;
  int n_err;

  adc_scan_ctrl #(.N(3), .N_CH(4), .SETTLE(2), .AVG_LOG(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .adc_q(adc_q),
    .mux_sel(mux_sel), .sample(sample), .busy(busy), .ack(ack),
    .res_valid(res_valid), .res_ch(res_ch), .res_data(res_data),
    .dbg_state(dbg_state)
  );

  adc_scan_ctrl #(.N(3), .N_CH(4), .SETTLE(0), .AVG_LOG(0)) u_dg (
    .clk(clk), .rst_n(rst_n), .req(req2), .adc_q(adc2),
    .mux_sel(mux_sel2), .sample(sample2), .busy(busy2), .ack(ack2),
    .res_valid(res_valid2), .res_ch(res_ch2), .res_data(res_data2),
    .dbg_state(dbg_state2)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // advance one cycle; inputs driven and outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // step until res_valid, at most 20 cycles; n = cycles taken
  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!res_valid && n < 20);
  endtask

  int n;
  int hits;
  logic [1:0] rr_seq [6];

  initial begin
    n_vec = 0;
    n_err = 0;
    rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd3;
    rr_seq[3] = 2'd0; rr_seq[4] = 2'd1; rr_seq[5] = 2'd3;

    // ---- reset with all requests high ----
    rst_n = 1'b0;
    req   = 4'b1111;
    adc_q = 3'd0;
    req2  = 4'b0000;
    adc2  = 3'd0;
    #12;
    chk("rst_mux_sel", 32'(mux_sel), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_ch", 32'(res_ch), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_dg_busy", 32'(busy2), 32'd0);
    step();
    chk("rst_hold_busy", 32'(busy), 32'd0);
    chk("rst_hold_sample", 32'(sample), 32'd0);
    rst_n = 1'b1;

    // ---- first grant after reset goes to ch0 ----
    step();
    chk("a_mux_sel", 32'(mux_sel), 32'd0);
    chk("a_busy", 32'(busy), 32'd1);
    chk("a_state_settle", 32'(dbg_state), 32'd1);
    step();
    chk("a_no_sample_settle", 32'(sample), 32'd0);
    step();
    chk("a_sample0", 32'(sample), 32'd1);
    adc_q = 3'd3;
    step();
    chk("a_sample1", 32'(sample), 32'd1);
    step();
    chk("a_res_valid", 32'(res_valid), 32'd1);
    chk("a_ack", 32'(ack), 32'b0001);
    chk("a_res_ch", 32'(res_ch), 32'd0);
    chk("a_res_data", 32'(res_data), 32'd3);
    req = 4'b0000;
    step();
    chk("a_valid_drop", 32'(res_valid), 32'd0);
    chk("a_ack_drop", 32'(ack), 32'd0);
    chk("a_idle", 32'(busy), 32'd0);

    // ---- single request ch2, averaging (5+6)>>1 = 5 ----
    req = 4'b0100;
    step();
    chk("b_mux_sel", 32'(mux_sel), 32'd2);
    step();
    chk("b_no_sample", 32'(sample), 32'd0);
    step();
    chk("b_sample0", 32'(sample), 32'd1);
    adc_q = 3'd5;
    step();
    chk("b_sample1", 32'(sample), 32'd1);
    adc_q = 3'd6;
    step();
    chk("b_res_valid", 32'(res_valid), 32'd1);
    chk("b_ack", 32'(ack), 32'b0100);
    chk("b_res_ch", 32'(res_ch), 32'd2);
    chk("b_res_data", 32'(res_data), 32'd5);
    chk("b_sample_off", 32'(sample), 32'd0);
    req = 4'b0000;
    step();
    chk("b_hold_data", 32'(res_data), 32'd5);
    chk("b_hold_ch", 32'(res_ch), 32'd2);
    chk("b_valid_drop", 32'(res_valid), 32'd0);

    // ---- fairness after wrap: ptr=3, req=0101 -> ch0 then ch2 ----
    adc_q = 3'd4;
    req = 4'b0101;
    wait_done(n);
    chk("c_lat0", 32'(n), 32'd5);
    chk("c_ch0", 32'(res_ch), 32'd0);
    chk("c_ack0", 32'(ack), 32'b0001);
    wait_done(n);
    chk("c_lat1", 32'(n), 32'd6);
    chk("c_ch1", 32'(res_ch), 32'd2);
    chk("c_ack1", 32'(ack), 32'b0100);
    chk("c_data1", 32'(res_data), 32'd4);
    req = 4'b0000;
    step();

    // ---- request ch1 dropped during SETTLE still completes ----
    req = 4'b0010;
    step();
    chk("e_state_settle", 32'(dbg_state), 32'd1);
    req = 4'b0000;
    wait_done(n);
    chk("e_lat", 32'(n), 32'd4);
    chk("e_ack", 32'(ack), 32'b0010);
    chk("e_res_ch", 32'(res_ch), 32'd1);
    step();

    // ---- reset asserted during SAMPLE discards the conversion ----
    req = 4'b1000;
    step();
    step();
    step();
    chk("f_sample", 32'(sample), 32'd1);
    req = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("f_sample_clr", 32'(sample), 32'd0);
    chk("f_busy_clr", 32'(busy), 32'd0);
    chk("f_valid_clr", 32'(res_valid), 32'd0);
    chk("f_ack_clr", 32'(ack), 32'd0);
    chk("f_mux_clr", 32'(mux_sel), 32'd0);
    chk("f_res_ch_clr", 32'(res_ch), 32'd0);
    chk("f_res_data_clr", 32'(res_data), 32'd0);
    chk("f_state_idle", 32'(dbg_state), 32'd0);
    step();
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (res_valid || busy) hits++;
    end
    chk("f_no_result", 32'(hits), 32'd0);

    // ---- round robin from ptr=0, req=1011 held ----
    req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      wait_done(n);
      chk("d_spacing", 32'(n), (k == 0) ? 32'd5 : 32'd6);
      chk("d_res_ch", 32'(res_ch), 32'(rr_seq[k]));
      chk("d_ack", 32'(ack), 32'(4'b0001 << rr_seq[k]));
    end
    req = 4'b0000;
    step();

    // ---- degenerate instance: SETTLE=0, AVG_LOG=0 ----
    req2 = 4'b0001;
    adc2 = 3'd7;
    step();
    chk("g_sample", 32'(sample2), 32'd1);
    chk("g_no_valid", 32'(res_valid2), 32'd0);
    step();
    chk("g_res_valid", 32'(res_valid2), 32'd1);
    chk("g_res_data", 32'(res_data2), 32'd7);
    chk("g_ack", 32'(ack2), 32'b0001);
    chk("g_sample_off", 32'(sample2), 32'd0);
    req2 = 4'b0000;
    step();
    chk("g_valid_drop", 32'(res_valid2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
